// File: rtl/seq_compare_ctrl.sv
// seq_compare_ctrl
//   Sequential unsigned 8-bit magnitude comparator. A single 3-bit compare
//   slice is reused across cycles, MSB-first:
//     S1: A[7:5] vs B[7:5]
//     S2: A[4:2] vs B[4:2]
//     S3: {0,A[1:0]} vs {0,B[1:0]}
//   With EARLY_EXIT=1 the compare ends at the first unequal slice. With
//   EARLY_EXIT=0 all three slices are always visited, giving constant latency.
//
// Parameters
//   EARLY_EXIT  1: stop at first unequal slice, 0: always visit S1..S3
// Ports
//   clk     rising-edge clock for all state
//   rst     synchronous active-high reset; aborts any compare in flight
//   start   compare request, only honoured in IDLE
//   A, B    operands, captured on the accepting edge
//   busy    high in S1, S2, S3
//   done    one-cycle pulse in DONE; result outputs are valid
//   A_gt_B, A_eq_B, A_lt_B
//           latched result, updated on the edge entering DONE
module seq_compare_ctrl #(
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       busy,
    output logic       done,
    output logic       A_gt_B,
    output logic       A_eq_B,
    output logic       A_lt_B
);

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] a_r;
    logic [7:0] b_r;

    // Shared 3-bit compare slice
    logic [2:0] sl_a;
    logic [2:0] sl_b;
    logic       sl_gt;
    logic       sl_lt;

    // First unequal verdict, only used when all slices are visited
    logic       dec;
    logic       dec_gt;

    logic       accept;
    logic       rec;
    logic       load_res;
    logic       res_gt;
    logic       res_lt;

    assign accept = (state == IDLE) && start;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        case (state)
            S1: begin
                sl_a = a_r[7:5];
                sl_b = b_r[7:5];
            end
            S2: begin
                sl_a = a_r[4:2];
                sl_b = b_r[4:2];
            end
            S3: begin
                sl_a = {1'b0, a_r[1:0]};
                sl_b = {1'b0, b_r[1:0]};
            end
            default: begin
                sl_a = '0;
                sl_b = '0;
            end
        endcase
    end

    assign sl_gt = (sl_a > sl_b);
    assign sl_lt = (sl_a < sl_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rec      = 1'b0;
        load_res = 1'b0;
        res_gt   = 1'b0;
        res_lt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = S1;
                end
            end
            S1, S2: begin
                busy     = 1'b1;
                state_nx = (state == S1) ? S2 : S3;
                if (sl_gt || sl_lt) begin
                    if (EARLY_EXIT != 0) begin
                        load_res = 1'b1;
                        res_gt   = sl_gt;
                        res_lt   = sl_lt;
                        state_nx = DONE;
                    end else begin
                        // only the most significant unequal slice decides
                        rec = !dec;
                    end
                end
            end
            S3: begin
                busy     = 1'b1;
                load_res = 1'b1;
                state_nx = DONE;
                if (dec) begin
                    res_gt = dec_gt;
                    res_lt = !dec_gt;
                end else begin
                    res_gt = sl_gt;
                    res_lt = sl_lt;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            dec    <= 1'b0;
            dec_gt <= 1'b0;
            A_gt_B <= 1'b0;
            A_eq_B <= 1'b0;
            A_lt_B <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= A;
                b_r <= B;
                dec <= 1'b0;
            end
            if (rec) begin
                dec    <= 1'b1;
                dec_gt <= sl_gt;
            end
            if (load_res) begin
                A_gt_B <= res_gt;
                A_lt_B <= res_lt;
                A_eq_B <= !res_gt && !res_lt;
            end
        end
    end

endmodule

// File: tb/tb_seq_compare_ctrl.sv
// Bench for seq_compare_ctrl. Two instances share all inputs:
//   index 1: EARLY_EXIT=1, index 0: EARLY_EXIT=0.
// Each accepted request pushes its expected result, done cycle and busy run
// length per instance; a forked monitor pops on every done pulse. Cycle
// numbers are the value of cyc during a cycle; a request whose start is high
// in cycle c0 must show done in cycle c0+latency.
module tb_seq_compare_ctrl;

    typedef struct {
        logic [2:0] res;   // {gt, eq, lt}
        int         cyc;
        int         blen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;

    logic       busy1, done1, gt1, eq1, lt1;
    logic       busy0, done0, gt0, eq0, lt0;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [2:0] held [2];
    int         blen [2];

    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [2:0] res_v [2];

    assign busy_v   = {busy1, busy0};
    assign done_v   = {done1, done0};
    assign res_v[0] = {gt0, eq0, lt0};
    assign res_v[1] = {gt1, eq1, lt1};

    seq_compare_ctrl #(.EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy1), .done(done1), .A_gt_B(gt1), .A_eq_B(eq1), .A_lt_B(lt1)
    );

    seq_compare_ctrl #(.EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy0), .done(done0), .A_gt_B(gt0), .A_eq_B(eq0), .A_lt_B(lt0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input int c0, input bit ee);
        exp_t m;
        int   lat;
        if (!ee)                    lat = 4;
        else if (a[7:5] != b[7:5])  lat = 2;
        else if (a[4:2] != b[4:2])  lat = 3;
        else                        lat = 4;
        m.res  = {a > b, a == b, a < b};
        m.cyc  = c0 + lat;
        m.blen = lat - 1;
        return m;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done_v[d] === 1'b1) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d got done=1 want no done", d, cyc);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        total++;
                        if (res_v[d] !== e.res) begin
                            bad++;
                            $display("FAIL result dut%0d got gt/eq/lt=%b want %b", d, res_v[d], e.res);
                        end
                        total++;
                        if (cyc !== e.cyc) begin
                            bad++;
                            $display("FAIL latency dut%0d done at cyc %0d want cyc %0d", d, cyc, e.cyc);
                        end
                        total++;
                        if (blen[d] !== e.blen) begin
                            bad++;
                            $display("FAIL busy_len dut%0d got %0d want %0d", d, blen[d], e.blen);
                        end
                        total++;
                        if (busy_v[d] !== 1'b0) begin
                            bad++;
                            $display("FAIL busy_in_done dut%0d got %b want 0", d, busy_v[d]);
                        end
                        held[d] = e.res;
                    end
                    blen[d] = 0;
                end else begin
                    if (busy_v[d] === 1'b1) blen[d] = blen[d] + 1;
                    else                    blen[d] = 0;
                    if (chk_en) begin
                        total++;
                        if (res_v[d] !== held[d]) begin
                            bad++;
                            $display("FAIL hold dut%0d cyc=%0d got gt/eq/lt=%b want %b", d, cyc, res_v[d], held[d]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL timeout pending dut0=%0d dut1=%0d want 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        q0.push_back(model(a, b, cyc, 1'b0));
        q1.push_back(model(a, b, cyc, 1'b1));
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (busy_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy dut%0d got %b want 0", d, busy_v[d]);
            end
            total++;
            if (done_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_done dut%0d got %b want 0", d, done_v[d]);
            end
            total++;
            if (res_v[d] !== 3'b000) begin
                bad++;
                $display("FAIL reset_result dut%0d got %b want 000", d, res_v[d]);
            end
            held[d] = 3'b000;
            blen[d] = 0;
        end
        rst = 1'b0;
        chk_en = 1'b1;
        // start low: must stay idle
        repeat (3) begin
            @(negedge clk);
            total++;
            if (busy_v !== 2'b00) begin
                bad++;
                $display("FAIL idle_busy got %b want 00", busy_v);
            end
        end
    endtask

    task automatic test_compare();
        logic [7:0] ta [10] = '{8'hAA, 8'h2A, 8'h5A, 8'hA9, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h1C, 8'h03};
        logic [7:0] tb [10] = '{8'h64, 8'h64, 8'h5A, 8'hAA, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h18, 8'h02};
        for (int i = 0; i < 10; i++) run_op(ta[i], tb[i]);
        for (int i = 0; i < 8; i++) run_op(8'($urandom), 8'($urandom));
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        A = 8'hAA;
        B = 8'h64;
        start = 1'b1;
        q0.push_back(model(8'hAA, 8'h64, cyc, 1'b0));
        q1.push_back(model(8'hAA, 8'h64, cyc, 1'b1));
        @(negedge clk);
        A = 8'h00;
        B = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c0;
        @(negedge clk);
        A = 8'hAA;
        B = 8'h64;
        start = 1'b1;
        c0 = cyc;
        // start high for cycles c0..c0+8: re-accepted every latency+1 cycles
        for (int t = 0; t < 9; t += 3) q1.push_back(model(8'hAA, 8'h64, c0 + t, 1'b1));
        for (int t = 0; t < 9; t += 5) q0.push_back(model(8'hAA, 8'h64, c0 + t, 1'b0));
        repeat (9) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        A = 8'h5A;
        B = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({busy_v[d], done_v[d], res_v[d]} !== 5'b00000) begin
                bad++;
                $display("FAIL abort dut%0d got busy/done/res=%b want 00000", d, {busy_v[d], done_v[d], res_v[d]});
            end
            held[d] = 3'b000;
        end
        chk_en = 1'b1;
        A = 8'h2A;
        B = 8'h64;
        start = 1'b1;
        q0.push_back(model(8'h2A, 8'h64, cyc, 1'b0));
        q1.push_back(model(8'h2A, 8'h64, cyc, 1'b1));
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        held[0] = 3'b000;
        held[1] = 3'b000;
        blen[0] = 0;
        blen[1] = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_compare();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_compare_ctrl.md
SEQ_COMPARE_CTRL -- requirements
Module: seq_compare_ctrl

Interface
REQ-001 The block SHALL have one parameter: EARLY_EXIT, default 1, where 1 ends the compare at the first unequal slice and 0 always evaluates all three slices (constant latency).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to compare; sampled on clk only in IDLE.
REQ-006 A  input  8  operand A; sampled on the accepting edge.
REQ-007 B  input  8  operand B; sampled on the accepting edge.
REQ-008 busy  output  1  high while a compare is in progress (states S1, S2, S3).
REQ-009 done  output  1  one-cycle pulse; result is valid.
REQ-010 A_gt_B  output  1  latched result: A > B, unsigned.
REQ-011 A_eq_B  output  1  latched result: A == B.
REQ-012 A_lt_B  output  1  latched result: A < B.

Function
REQ-013 The block SHALL compare unsigned 8-bit operands using a single 3-bit magnitude-compare slice, reused across cycles, MSB-first.
REQ-014 Slice 1 SHALL be A[7:5] vs B[7:5], slice 2 SHALL be A[4:2] vs B[4:2], and slice 3 SHALL be {1'b0,A[1:0]} vs {1'b0,B[1:0]}; slices SHALL NOT overlap.
REQ-015 The FSM states SHALL be IDLE, S1, S2, S3 and DONE, with one state per cycle.
REQ-016 In IDLE with start=1, the block SHALL latch A and B into internal registers, go to S1, and assert busy from the next cycle.
REQ-017 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-018 In Sn with slice n unequal and EARLY_EXIT=1, the block SHALL set the result from slice n (gt or lt) and go to DONE.
REQ-019 In Sn with slice n equal and n<3, the block SHALL go to Sn+1.
REQ-020 With EARLY_EXIT=0, the block SHALL record the first unequal slice's verdict, keep it through the remaining slices, and go to DONE only from S3.
REQ-021 In S3 with all slices equal, the block SHALL set A_eq_B=1 and go to DONE.
REQ-022 In DONE, done SHALL be 1 and busy 0, and the next state SHALL be IDLE unconditionally.
REQ-023 Result outputs SHALL update on the edge entering DONE and hold until the next result update or reset.
REQ-024 Exactly one of A_gt_B, A_eq_B and A_lt_B SHALL be high after the first completed compare.
REQ-025 Latency SHALL be measured from the accepting edge to the edge raising done, with done visible for one cycle.
REQ-026 With EARLY_EXIT=1, latency SHALL be 2, 3 or 4 cycles for a decision at slice 1, 2 or 3 (equal operands: 4).
REQ-027 With EARLY_EXIT=0, latency SHALL always be 4 cycles.
REQ-028 start in S1..S3 or DONE SHALL be ignored (no queuing), and A/B changes after acceptance SHALL NOT affect the result.
REQ-029 Back-to-back operation: a start held high SHALL be accepted again in the IDLE cycle following DONE, giving a minimum issue interval of latency+1 cycles.

Reset
REQ-030 On a clk edge with rst=1, the block SHALL enter IDLE with busy=0, done=0, A_gt_B=0, A_eq_B=0, A_lt_B=0, and operand registers cleared.
REQ-031 rst SHALL take priority over start and over any in-flight compare: the compare SHALL be aborted with no done pulse and no result update.
REQ-032 In the first cycle after rst deasserts, the block SHALL be in IDLE and SHALL accept start in that same cycle.

Verification
REQ-033 A=0xAA, B=0x64, start one cycle, EARLY_EXIT=1 -> done 2 cycles after acceptance; A_gt_B=1, others 0; busy high for exactly 1 cycle.
REQ-034 A=0x2A, B=0x64 -> decided at slice 1 (001<011); A_lt_B=1; done at +2.
REQ-035 A=B=0x5A -> A_eq_B=1 at +4; busy high 3 cycles.
REQ-036 A=0xA9, B=0xAA -> slices 1 and 2 equal, slice 3 01<10; A_lt_B=1 at +4; with EARLY_EXIT=0, A=0xAA, B=0x64 -> A_gt_B=1 at +4.
REQ-037 Start 0xAA/0x64, then pulse start with 0x00/0xFF while busy -> second request ignored, single done, A_gt_B=1.
REQ-038 Start 0x5A/0x5A, assert rst in S2 -> no done; all outputs 0 next cycle; a new start on the first post-reset cycle completes normally.
